regfile_scoreboard: RTL
=======================

Name: regfile_scoreboard

Overview:
- Parametrised multi-read-port register file for the pipelined MIPS core.
- Generalises the fixed 32x32, 2-read-port file: width, depth and read-port count are configurable.
- Adds write-through bypass, a hardwired-zero register 0, and a per-register pending-write scoreboard.
- Sits between decode (reads, issue marking) and writeback (write, busy clear); hazard logic consumes the busy flags.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; depth = 2**ADDR_W registers.
- NREAD, 2, number of independent read ports.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  reset, asynchronous, active-low.
- rd_addr  input  NREAD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
- rd_data  output  NREAD*DATA_W  read data; port k uses bits [k*DATA_W +: DATA_W].
- rd_busy  output  NREAD  port k's register has a pending write.
- we  input  1  writeback write enable.
- wa  input  ADDR_W  write address.
- wd  input  DATA_W  write data.
- iss_valid  input  1  mark a register as pending (instruction issued).
- iss_addr  input  ADDR_W  destination register being issued.
- flush  input  1  clear all pending flags (pipeline flush).
- busy_cnt  output  ADDR_W+1  registered count of currently busy registers.

Behaviour:
- Reset (reset=0, asynchronous):
  - all registers -> 0, all busy flags -> 0, busy_cnt -> 0.
  - rd_data reads 0 for every address.
  - Reset asserted mid-operation discards any in-flight write or issue in that cycle.
- Write:
  - On a rising edge with we=1 and wa!=0, reg[wa] <= wd.
  - Writes to address 0 are ignored.
- Read:
  - Combinational, zero latency, all NREAD ports independent.
  - Address 0 always returns 0 with rd_busy=0.
- Bypass:
  - If we=1, wa==rd_addr[k] and wa!=0, rd_data[k]=wd in the same cycle, not the stale register content.
  - rd_busy[k] is forced to 0 for that port in that cycle.
- Scoreboard update, per rising edge, applied in this order:
  1. flush=1 clears all busy flags.
  2. we=1 and wa!=0 clears busy[wa].
  3. iss_valid=1 and iss_addr!=0 sets busy[iss_addr].
  - Later steps win: issue and writeback to the same address in one cycle leaves it busy (new producer).
  - flush together with issue leaves only iss_addr busy.
- Boundary cases:
  - iss_valid to address 0 has no effect.
  - Issuing an already-busy register keeps it busy; there is no count of outstanding producers.
  - Writing a non-busy register updates data and leaves busy clear.
- busy_cnt:
  - Registered popcount of the busy flags after the update.
  - Valid one cycle after the edge that changes them.
  - Range 0 .. 2**ADDR_W-1.
- Widths: no arithmetic on data; the address compare is full ADDR_W width.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined: write-through bypass and the rd_busy masking as described above.
- Undefined:
  - rd_data[k] returns the stored register value; a same-cycle write becomes visible from the next cycle.
  - rd_busy[k] reflects the current busy flag without masking.
  - Scoreboard behaviour and busy_cnt are unchanged.

Test Plan:
- Reset then read all addresses -> every rd_data=0, rd_busy=0, busy_cnt=0; assert reset mid-write of 0xDEADBEEF to r5 -> r5 reads 0 after reset.
- Write r7=0x12345678, then next cycle read r7 on port 0 and port 1 -> both 0x12345678; write r0=0xFFFFFFFF -> r0 reads 0.
- With REGFILE_BYPASS_EN: we=1, wa=9, wd=0xCAFEF00D, rd_addr port0=9 in the same cycle -> rd_data port0=0xCAFEF00D, rd_busy=0. Without the macro -> old value 0 that cycle, 0xCAFEF00D next cycle.
- Issue r3, r4, r5 on consecutive cycles -> busy_cnt 1, 2, 3; then write r4 -> busy[4]=0, busy_cnt=2.
- Same cycle: we=1 wa=6, iss_valid=1 iss_addr=6 with r6 busy -> r6 stays busy, data updated; iss_addr=0 -> no change, busy_cnt unchanged.
- Eight registers busy, then flush=1 with iss_valid=1 iss_addr=10 -> only r10 busy, busy_cnt=1 the next cycle.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Parametrised multi-read-port register file with hardwired r0 and a pending-write scoreboard.
// Optional write-through bypass selected by the REGFILE_BYPASS_EN macro.
module regfile_scoreboard #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NREAD  = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREAD*ADDR_W-1:0]   rd_addr,
  output logic [NREAD*DATA_W-1:0]   rd_data,
  output logic [NREAD-1:0]          rd_busy,
  input  logic                      we,
  input  logic [ADDR_W-1:0]         wa,
  input  logic [DATA_W-1:0]         wd,
  input  logic                      iss_valid,
  input  logic [ADDR_W-1:0]         iss_addr,
  input  logic                      flush,
  output logic [ADDR_W:0]           busy_cnt
);

  localparam int unsigned Depth = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [Depth];
  logic [Depth-1:0]  busy_q, busy_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              wr_en;

  assign wr_en = we && (wa != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[wa] <= wd;
    end
  end

  // Later steps override earlier ones: flush, then writeback clear, then issue set.
  always_comb begin
    busy_d = busy_q;
    if (flush) busy_d = '0;
    if (wr_en) busy_d[wa] = 1'b0;
    if (iss_valid && (iss_addr != '0)) busy_d[iss_addr] = 1'b1;
  end

  always_comb begin
    cnt_d = '0;
    for (int unsigned i = 0; i < Depth; i++) cnt_d = cnt_d + {{ADDR_W{1'b0}}, busy_d[i]};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_cnt = cnt_q;

  logic [ADDR_W-1:0] ra;

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    ra      = '0;
    for (int unsigned k = 0; k < NREAD; k++) begin
      ra = rd_addr[k*ADDR_W +: ADDR_W];
      rd_data[k*DATA_W +: DATA_W] = mem_q[ra];
      rd_busy[k]                  = busy_q[ra];
`ifdef REGFILE_BYPASS_EN
      if (wr_en && (wa == ra)) begin
        rd_data[k*DATA_W +: DATA_W] = wd;
        rd_busy[k]                  = 1'b0;
      end
`else
`endif
      if ((ra == '0) || !reset) begin
        rd_data[k*DATA_W +: DATA_W] = '0;
        rd_busy[k]                  = 1'b0;
      end
    end
  end

endmodule
